// File: rtl/mau_pkg.sv
// Shared types for the multi-beat memory access unit: FSM states, the queued
// request record and the beat-count helper.
package mau_pkg;

    localparam int MAU_DATA_W = 16;
    localparam int MAU_BUS_W  = 8;
    localparam int MAU_ADDR_W = 16;
    localparam int MAU_DST_W  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } mau_state_t;

    typedef struct packed {
        logic                  we;
        logic                  full;
        logic                  sgn;
        logic [MAU_ADDR_W-1:0] addr;
        logic [MAU_DATA_W-1:0] wdata;
        logic [MAU_DST_W-1:0]  dst;
    } mau_req_t;

    function automatic int beats_of(input logic full);
        return full ? MAU_DATA_W / MAU_BUS_W : 1;
    endfunction

endpackage

// File: rtl/mau_multibeat_if.sv
// CPU request, memory bus and writeback signals of the MAU. The master view is
// the MAU itself; the slave view is the CPU/memory side.
interface mau_multibeat_if #(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 8,
    parameter int ADDR_W = 16,
    parameter int DST_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_full;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DST_W-1:0]  req_dst;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic [BUS_W-1:0]  mem_rdata;
    logic              mem_res;
    logic              out_en;
    logic [DATA_W-1:0] out;
    logic [DST_W-1:0]  o_dst;
    logic              st_done;
    logic              busy;

    modport master (
        input  req_valid, req_we, req_full, req_signed, req_addr, req_wdata, req_dst,
        input  mem_rdata, mem_res,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output out_en, out, o_dst, st_done, busy
    );

    modport slave (
        output req_valid, req_we, req_full, req_signed, req_addr, req_wdata, req_dst,
        output mem_rdata, mem_res,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  out_en, out, o_dst, st_done, busy
    );
endinterface

// File: rtl/mau_req_fifo.sv
// Request queue between the execute stage and the beat sequencer; head is the
// oldest entry and is valid whenever empty=0.
module mau_req_fifo
    import mau_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  mau_req_t din,
    output logic     full,
    output logic     empty,
    output mau_req_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mau_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/mau_multibeat.sv
// Memory access unit: queues load/store requests and splits each into BUS_W
// beats on a req/res bus, assembling loads little-endian with optional sign extension.
module mau_multibeat
    import mau_pkg::*;
#(
    parameter int DATA_W = MAU_DATA_W,
    parameter int BUS_W  = MAU_BUS_W,
    parameter int ADDR_W = MAU_ADDR_W,
    parameter int DST_W  = MAU_DST_W,
    parameter int DEPTH  = 2
) (
    input logic            cpu_clk,
    input logic            cpu_rst,
    mau_multibeat_if.master bus
);
    localparam int NB_MAX = DATA_W / BUS_W;
    localparam int BEAT_W = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

    if (DATA_W % BUS_W != 0 || DEPTH < 1) begin : g_bad_cfg
        $error("mau_multibeat: DATA_W must be a multiple of BUS_W and DEPTH >= 1");
    end
    if (DATA_W != MAU_DATA_W || BUS_W != MAU_BUS_W || ADDR_W != MAU_ADDR_W || DST_W != MAU_DST_W)
    begin : g_pkg_mismatch
        $error("mau_multibeat: widths must match the request record in mau_pkg");
    end

    mau_state_t        state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    mau_req_t          din, head;
    logic              full, empty, push, pop, last, fire;
    logic [DATA_W-1:0] asm_q, asm_nxt, ld_res, out_q;
    logic [DST_W-1:0]  dst_q;
    logic              out_en_q, st_done_q;

    assign push = bus.req_valid && !full;
    assign din  = '{we: bus.req_we, full: bus.req_full, sgn: bus.req_signed,
                    addr: bus.req_addr, wdata: bus.req_wdata, dst: bus.req_dst};

    mau_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (cpu_clk),
        .rst  (cpu_rst),
        .push (push),
        .pop  (pop),
        .din  (din),
        .full (full),
        .empty(empty),
        .head (head)
    );

    assign last = (int'(beat) == beats_of(head.full) - 1);
    assign fire = (state == ACCESS) && bus.mem_res;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = ACCESS;
                    beat_nxt  = '0;
                end
            end
            ACCESS: begin
                if (bus.mem_res) begin
                    if (last) begin
                        state_nxt = IDLE;
                        pop       = 1'b1;
                    end else begin
                        beat_nxt = beat + BEAT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Final beat is merged combinationally so the result lands in out on the
    // same edge that retires the request.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[beat*BUS_W +: BUS_W] = bus.mem_rdata;
        if (head.full)     ld_res = asm_nxt;
        else if (head.sgn) ld_res = DATA_W'($signed(bus.mem_rdata));
        else               ld_res = DATA_W'(bus.mem_rdata);
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            beat      <= '0;
            asm_q     <= '0;
            out_q     <= '0;
            dst_q     <= '0;
            out_en_q  <= 1'b0;
            st_done_q <= 1'b0;
        end else begin
            beat      <= beat_nxt;
            out_en_q  <= 1'b0;
            st_done_q <= 1'b0;
            if (fire && !head.we) asm_q <= asm_nxt;
            if (fire && last) begin
                if (head.we) begin
                    st_done_q <= 1'b1;
                end else begin
                    out_q    <= ld_res;
                    dst_q    <= head.dst;
                    out_en_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = !full;
    assign bus.busy      = !empty || (state != IDLE);
    assign bus.mem_req   = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && head.we;
    assign bus.mem_addr  = head.addr + ADDR_W'(beat);
    assign bus.mem_wdata = ((state == ACCESS) && head.we) ? head.wdata[beat*BUS_W +: BUS_W] : '0;
    assign bus.out_en    = out_en_q;
    assign bus.out       = out_q;
    assign bus.o_dst     = dst_q;
    assign bus.st_done   = st_done_q;
endmodule

// File: tb/tb_mau_multibeat.sv
// Directed bench for mau_multibeat: a negedge bus responder with a byte memory,
// strobe/beat logs, and hand-computed expectations.
module tb_mau_multibeat;
    import mau_pkg::*;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          cyc;
    } beat_t;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    always #5 cpu_clk = ~cpu_clk;

    mau_multibeat_if #(.DATA_W(16), .BUS_W(8), .ADDR_W(16), .DST_W(4)) bus ();

    mau_multibeat #(.DATA_W(16), .BUS_W(8), .ADDR_W(16), .DST_W(4), .DEPTH(2)) dut (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          res_delay = 0;
    logic        force_res = 1'b0;
    int          st_cnt = 0;
    beat_t       beat_log [$];
    logic [19:0] out_log [$];
    logic [7:0]  mem_m [logic [15:0]];

    always @(posedge cpu_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bl_addr(input int i);
        return (i < beat_log.size()) ? {16'h0, beat_log[i].addr} : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] bl_wd(input int i);
        return (i < beat_log.size()) ? {23'h0, beat_log[i].we, beat_log[i].wd} : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] bl_gap(input int i);
        return (i < beat_log.size()) ? beat_log[i].cyc - beat_log[i-1].cyc : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] ol(input int i);
        return (i < out_log.size()) ? {12'h0, out_log[i]} : 32'hDEAD_BEEF;
    endfunction

    // Responder and strobe monitor share one process so log order is deterministic.
    initial begin
        int          wait_cnt;
        logic [31:0] cur, held;
        wait_cnt = 0;
        held = '0;
        bus.mem_res = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge cpu_clk);
            if (bus.out_en)  out_log.push_back({bus.out, bus.o_dst});
            if (bus.st_done) st_cnt++;
            bus.mem_res = force_res;
            if (!bus.mem_req) begin
                wait_cnt = 0;
            end else if (!force_res) begin
                cur = {7'h0, bus.mem_we, bus.mem_addr, bus.mem_wdata};
                if (wait_cnt == 0) held = cur;
                else chk("hold", cur, held);
                if (wait_cnt < res_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    bus.mem_res = 1'b1;
                    bus.mem_rdata = mem_m.exists(bus.mem_addr) ? mem_m[bus.mem_addr] : 8'h00;
                    beat_log.push_back('{we: bus.mem_we, addr: bus.mem_addr, wd: bus.mem_wdata, cyc: cyc});
                    if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
                end
            end
        end
    end

    task automatic clr();
        beat_log.delete();
        out_log.delete();
        st_cnt = 0;
    endtask

    // Called at a negedge; returns at the negedge right after the push edge.
    task automatic send(input logic we, input logic full, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wd, input logic [3:0] dst);
        int n;
        n = 0;
        bus.req_we = we;
        bus.req_full = full;
        bus.req_signed = sgn;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        bus.req_dst = dst;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(negedge cpu_clk);
            n++;
        end
        @(negedge cpu_clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge cpu_clk);
            n++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
        repeat (2) @(negedge cpu_clk);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_full = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_dst = '0;
        repeat (3) @(negedge cpu_clk);

        chk("rst_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_strobes", {bus.out_en, bus.st_done}, 0);
        chk("rst_out", {bus.out, bus.o_dst}, 0);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        // signed byte load, then the same byte zero-extended
        mem_m[16'h1234] = 8'h80;
        res_delay = 1;
        clr();
        send(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 4'd5);
        chk("lat1_req", bus.mem_req, 0);
        @(negedge cpu_clk);
        chk("lat2_req", bus.mem_req, 1);
        chk("lat2_addr", bus.mem_addr, 16'h1234);
        wait_idle("lds");
        chk("lds_nbeat", beat_log.size(), 1);
        chk("lds_addr", bl_addr(0), 16'h1234);
        chk("lds_nout", out_log.size(), 1);
        chk("lds_out", ol(0), {16'hFF80, 4'd5});

        clr();
        send(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 4'd6);
        wait_idle("ldu");
        chk("ldu_nout", out_log.size(), 1);
        chk("ldu_out", ol(0), {16'h0080, 4'd6});

        // full load wrapping the address space
        mem_m[16'hFFFF] = 8'hCD;
        mem_m[16'h0000] = 8'hAB;
        res_delay = 0;
        clr();
        send(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0, 4'd7);
        wait_idle("ldf");
        chk("ldf_nbeat", beat_log.size(), 2);
        chk("ldf_addr0", bl_addr(0), 16'hFFFF);
        chk("ldf_addr1", bl_addr(1), 16'h0000);
        chk("ldf_out", ol(0), {16'hABCD, 4'd7});
        chk("ldf_nout", out_log.size(), 1);

        // full store with slow responses
        res_delay = 3;
        clr();
        send(1'b1, 1'b1, 1'b1, 16'h2000, 16'hBEEF, 4'd0);
        wait_idle("stf");
        chk("stf_nbeat", beat_log.size(), 2);
        chk("stf_b0", bl_wd(0), {1'b1, 8'hEF});
        chk("stf_b1", bl_wd(1), {1'b1, 8'hBE});
        chk("stf_addr1", bl_addr(1), 16'h2001);
        chk("stf_done", st_cnt, 1);
        chk("stf_no_out", out_log.size(), 0);
        chk("stf_out_kept", bus.out, 16'hABCD);

        // three back-to-back requests into a two-entry queue
        mem_m[16'h3000] = 8'h11;
        mem_m[16'h3001] = 8'hF2;
        res_delay = 0;
        clr();
        send(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0, 4'd1);
        send(1'b0, 1'b0, 1'b1, 16'h3001, 16'h0, 4'd2);
        chk("q_full_ready", bus.req_ready, 0);
        send(1'b1, 1'b0, 1'b0, 16'h3002, 16'h1255, 4'd3);
        wait_idle("q");
        chk("q_nbeat", beat_log.size(), 3);
        chk("q_addr0", bl_addr(0), 16'h3000);
        chk("q_addr1", bl_addr(1), 16'h3001);
        chk("q_b2", bl_wd(2), {1'b1, 8'h55});
        chk("q_gap1", bl_gap(1), 2);
        chk("q_gap2", bl_gap(2), 2);
        chk("q_out0", ol(0), {16'h0011, 4'd1});
        chk("q_out1", ol(1), {16'hFFF2, 4'd2});
        chk("q_done", st_cnt, 1);

        // reset in the middle of a full load
        mem_m[16'h4000] = 8'h12;
        mem_m[16'h4001] = 8'h34;
        res_delay = 2;
        clr();
        send(1'b0, 1'b1, 1'b0, 16'h4000, 16'h0, 4'd9);
        n = 0;
        while (beat_log.size() < 1 && n < 100) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("ar_beat0", beat_log.size(), 1);
        @(posedge cpu_clk);
        #2 cpu_rst = 1'b1;
        #1;
        chk("ar_mem_req", bus.mem_req, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_ready", bus.req_ready, 1);
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;
        repeat (5) @(negedge cpu_clk);
        chk("ar_no_out", out_log.size(), 0);
        chk("ar_idle", bus.busy, 0);
        chk("ar_out", bus.out, 0);
        send(1'b0, 1'b0, 1'b0, 16'h4001, 16'h0, 4'd10);
        wait_idle("ar_new");
        chk("ar_new_out", ol(0), {16'h0034, 4'd10});

        // mem_res while idle is ignored
        clr();
        force_res = 1'b1;
        repeat (3) @(negedge cpu_clk);
        force_res = 1'b0;
        @(negedge cpu_clk);
        chk("ir_busy", bus.busy, 0);
        chk("ir_mem_req", bus.mem_req, 0);
        chk("ir_strobes", st_cnt + out_log.size(), 0);
        chk("ir_out", {bus.out, bus.o_dst}, {16'h0034, 4'd10});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
